aes_encrypt_controller: RTL and testbench

Iterative AES-128 encryption sequencer. Accepts one plaintext/key pair over a valid/ready handshake and runs the initial AddRoundKey plus rounds 1..10 at one round per clock. Reuses the team's combinational round datapath and key-expansion blocks against a single state register and a single round-key register. Returns the ciphertext over a second valid/ready handshake. Sits between the bus/DMA front end and the AES datapath.

---
 rtl/aes_encrypt_controller.sv | 179 +++++++++++++++++
 tb/tb_aes_encrypt_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_controller.sv
// Iterative AES-128 encryptor: one round per clock over a single
// state register and a single round-key register, valid/ready on both sides.
module aes_encrypt_controller #(
  parameter int N         = 4,
  parameter int NumRounds = 10,
  localparam int KeySize  = N*N*8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [KeySize-1:0] plain_text,
  input  logic [KeySize-1:0] key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [KeySize-1:0] cipher_text,
  output logic               busy
);

  localparam logic [3:0] LastRnd = 4'(NumRounds);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } fsm_e;

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes and ShiftRows fused: out[r][c] = S(in[r][(c+r)%4])
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] =
          sb(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_exp(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sb(w3[23:16]), sb(w3[15:8]),
          sb(w3[7:0]), sb(w3[31:24])};
    t  = t ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] ct_q, ct_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] nk, sr, rnd_out;
  logic         last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      st_q   <= '0;
      rk_q   <= '0;
      ct_q   <= '0;
      rnd_q  <= '0;
      rcon_q <= 8'h01;
    end else begin
      fsm_q  <= fsm_d;
      st_q   <= st_d;
      rk_q   <= rk_d;
      ct_q   <= ct_d;
      rnd_q  <= rnd_d;
      rcon_q <= rcon_d;
    end
  end

  assign nk      = key_exp(rk_q, rcon_q);
  assign sr      = sub_shift(st_q);
  assign last    = (rnd_q == LastRnd);
  assign rnd_out = (last ? sr : mix_cols(sr)) ^ nk;

  always_comb begin
    fsm_d     = fsm_q;
    st_d      = st_q;
    rk_d      = rk_q;
    ct_d      = ct_q;
    rnd_d     = rnd_q;
    rcon_d    = rcon_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (fsm_q)
      IDLE: in_ready = 1'b1;
      ROUND: begin
        busy   = 1'b1;
        st_d   = rnd_out;
        rk_d   = nk;
        rcon_d = xt(rcon_q);
        rnd_d  = rnd_q + 4'd1;
        if (last) begin
          ct_d  = rnd_out;
          rnd_d = '0;
          fsm_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
    // Shared capture path for IDLE and the DONE back-to-back case
    if (in_valid && in_ready) begin
      st_d   = plain_text ^ key;
      rk_d   = key;
      rnd_d  = 4'd1;
      rcon_d = 8'h01;
      fsm_d  = ROUND;
    end
  end

  assign cipher_text = ct_q;

endmodule

// File: tb/tb_aes_encrypt_controller.sv
// Directed bench for aes_encrypt_controller using FIPS-197 vectors.
// Inputs and samples are both taken on the falling edge.
module tb_aes_encrypt_controller;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plain_text;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] cipher_text;
  logic         busy;

  int errs;
  int checks;

  aes_encrypt_controller dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .plain_text(plain_text),
    .key(key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cipher_text(cipher_text),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accept one block, scramble the inputs, wait for out_valid
  task automatic run_blk(
    input logic [127:0] pt,
    input logic [127:0] k,
    input logic [127:0] exp,
    input string        tag
  );
    int n;
    int nb;
    @(negedge clk);
    in_valid   = 1'b1;
    plain_text = pt;
    key        = k;
    check({tag, "_rdy"}, 128'(in_ready), 128'd1);
    @(negedge clk);
    in_valid   = 1'b0;
    plain_text = ~pt;
    key        = ~k;
    n  = 1;
    nb = int'(busy);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
      nb += int'(busy);
    end
    check({tag, "_lat"}, 128'(n - 1), 128'd10);
    check({tag, "_busy"}, 128'(nb), 128'd10);
    check({tag, "_ct"}, cipher_text, exp);
  endtask

  initial begin
    int n;
    int g;
    int bad;
    errs       = 0;
    checks     = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    plain_text = '0;
    key        = '0;
    repeat (3) @(negedge clk);
    check("rst_ov", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_rdy", 128'(in_ready), 128'd1);
    check("rst_ct", cipher_text, 128'd0);
    rst_n = 1'b1;

    // FIPS-197 App. B, inputs scrambled after acceptance
    out_ready = 1'b1;
    run_blk(P1, K1, C1, "v1");
    @(negedge clk);
    check("v1_ovlo", 128'(out_valid), 128'd0);
    check("v1_idle", 128'(in_ready), 128'd1);

    // App. C.1 with 20 cycles of backpressure
    out_ready = 1'b0;
    run_blk(P2, K2, C2, "v2");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid   = (i == 5);
      plain_text = P1;
      key        = K1;
      @(negedge clk);
      if (!out_valid || busy || in_ready || cipher_text !== C2)
        bad++;
    end
    check("bp_hold", 128'(bad), 128'd0);
    check("bp_ct", cipher_text, C2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ovlo", 128'(out_valid), 128'd0);
    check("bp_idle", 128'(in_ready), 128'd1);
    check("bp_busy", 128'(busy), 128'd0);

    // Back-to-back with in_valid held
    in_valid   = 1'b1;
    plain_text = P1;
    key        = K1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    check("b2b_ct1", cipher_text, C1);
    plain_text = P2;
    key        = K2;
    @(negedge clk);
    check("b2b_acc", 128'(busy), 128'd1);
    check("b2b_ovlo", 128'(out_valid), 128'd0);
    in_valid = 1'b0;
    g = 1;
    while (!out_valid && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("b2b_gap", 128'(g), 128'd11);
    check("b2b_ct2", cipher_text, C2);
    @(negedge clk);
    check("b2b_end", 128'(out_valid), 128'd0);

    // Reset around round 5
    in_valid   = 1'b1;
    plain_text = P1;
    key        = K1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mr_ov", 128'(out_valid), 128'd0);
    check("mr_busy", 128'(busy), 128'd0);
    check("mr_rdy", 128'(in_ready), 128'd1);
    check("mr_ct", cipher_text, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || busy) bad++;
    end
    check("mr_quiet", 128'(bad), 128'd0);
    run_blk(P2, K2, C2, "mr_v2");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
